music_playback_ctrl: RTL and testbench

Playback sequencer for the 24-bit-address, 8-bit-data song ROM (combinational read). Holds a song's start/end address range, steps the ROM address once per sample period and registers each ROM byte into an audio sample output with a one-cycle valid strobe. Supports play/pause/stop/loop and sits between the menu/UI logic and the PWM/DAC output stage.

---
 rtl/music_playback_ctrl_if.sv | 28 ++
 rtl/music_playback_ctrl.sv | 120 ++++++++++++
 tb/tb_music_playback_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/music_playback_ctrl_if.sv
// Control, ROM and audio-sample signals of the playback sequencer.
// master = UI/ROM side, slave = the sequencer itself.
interface music_playback_ctrl_if;
   logic        play;
   logic        pause;
   logic        stop;
   logic        loop_en;
   logic [23:0] start_addr;
   logic [23:0] end_addr;
   logic [23:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        done;
   logic        busy;
   logic        bad_range;
   logic [1:0]  state;

   modport master (
      output play, pause, stop, loop_en, start_addr, end_addr, rom_data,
      input  rom_addr, sample_out, sample_valid, done, busy, bad_range, state
   );

   modport slave (
      input  play, pause, stop, loop_en, start_addr, end_addr, rom_data,
      output rom_addr, sample_out, sample_valid, done, busy, bad_range, state
   );
endinterface

// File: rtl/music_playback_ctrl.sv
// Song ROM playback sequencer: steps the ROM address once per sample period
// and registers each byte as an audio sample with a one-cycle valid strobe.
module music_playback_ctrl #(
   parameter int unsigned CLK_DIV = 2500,
   parameter int unsigned CNT_W   = 12,
   parameter logic [7:0]  SILENCE = 8'h80
) (
   input  logic                  clk,
   input  logic                  reset_n,
   music_playback_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_PLAY   = 2'b01,
      ST_PAUSED = 2'b10,
      ST_DONE   = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] TICK = CNT_W'(CLK_DIV - 1);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [23:0]      addr;
   logic [23:0]      start_q;
   logic [23:0]      end_q;
   logic [7:0]       sample;
   logic             valid_q;
   logic             done_q;
   logic             bad_q;

   logic             do_start;
   logic             do_resume;
   logic             do_pause;
   logic             run;
   logic             range_ok;

   // Command decode: stop > play > pause; a play held in PLAY masks pause.
   always_comb begin
      do_start  = 1'b0;
      do_resume = 1'b0;
      do_pause  = 1'b0;
      run       = 1'b0;
      if (!bus.stop) begin
         if (bus.play) begin
            do_start  = (st == ST_IDLE) || (st == ST_DONE);
            do_resume = (st == ST_PAUSED);
            run       = (st == ST_PLAY);
         end else begin
            do_pause  = bus.pause && (st == ST_PLAY);
            run       = !bus.pause && (st == ST_PLAY);
         end
      end
   end

   assign range_ok = (bus.end_addr >= bus.start_addr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st      <= ST_IDLE;
         cnt     <= '0;
         addr    <= '0;
         start_q <= '0;
         end_q   <= '0;
         sample  <= SILENCE;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         bad_q   <= 1'b0;
         if (bus.stop) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            addr   <= '0;
            sample <= SILENCE;
         end else if (do_start) begin
            if (range_ok) begin
               start_q <= bus.start_addr;
               end_q   <= bus.end_addr;
               addr    <= bus.start_addr;
               cnt     <= '0;
               st      <= ST_PLAY;
            end else begin
               bad_q <= 1'b1;
            end
         end else if (do_resume) begin
            st <= ST_PLAY;
         end else if (do_pause) begin
            st <= ST_PAUSED;
         end else if (run) begin
            if (cnt == TICK) begin
               cnt     <= '0;
               sample  <= bus.rom_data;
               valid_q <= 1'b1;
               if (addr != end_q) begin
                  addr <= addr + 24'd1;
               end else if (bus.loop_en) begin
                  addr <= start_q;
               end else begin
                  st     <= ST_DONE;
                  done_q <= 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.rom_addr     = addr;
   assign bus.sample_out   = sample;
   assign bus.sample_valid = valid_q;
   assign bus.done         = done_q;
   assign bus.bad_range    = bad_q;
   assign bus.busy         = (st == ST_PLAY) || (st == ST_PAUSED);
   assign bus.state        = st;

endmodule

// File: tb/tb_music_playback_ctrl.sv
// Bench for music_playback_ctrl: directed and randomized songs checked
// against an arithmetic model of the expected sample stream.
module tb_music_playback_ctrl;

   localparam int unsigned DIV = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   music_playback_ctrl_if bus ();

   logic [7:0] rom_mem [64];
   assign bus.rom_data = rom_mem[bus.rom_addr[5:0]];

   music_playback_ctrl #(
      .CLK_DIV (DIV),
      .CNT_W   (3),
      .SILENCE (8'h80)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned n_pass = 0;
   int unsigned n_fail = 0;
   int unsigned n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, bus.state, 2'b00);
      chk({tag, "_addr"}, bus.rom_addr, 24'h0);
      chk({tag, "_sample"}, bus.sample_out, 8'h80);
      chk({tag, "_valid"}, bus.sample_valid, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   // Issue play with a range, then scramble the range inputs to show they are latched.
   task automatic start_song(input logic [23:0] s, input logic [23:0] e, input logic lp);
      bus.start_addr = s;
      bus.end_addr   = e;
      bus.loop_en    = lp;
      bus.play       = 1'b1;
      step();
      bus.play       = 1'b0;
      bus.start_addr = 24'($urandom);
      bus.end_addr   = 24'($urandom);
      chk("start_state", bus.state, 2'b01);
      chk("start_busy", bus.busy, 1'b1);
      chk("start_addr", bus.rom_addr, s);
   endtask

   // Samples k0..k1-1 of a song [s,e]: one every DIV cycles, data from the ROM.
   task automatic run_song(input logic [23:0] s, input logic [23:0] e, input logic lp,
                           input int unsigned k0, input int unsigned k1);
      int unsigned len;
      logic [23:0] ea;
      logic [23:0] na;
      logic        last;
      len = int'(e) - int'(s) + 1;
      for (int unsigned k = k0; k < k1; k++) begin
         for (int unsigned j = 1; j < DIV; j++) begin
            step();
            chk("gap_valid", bus.sample_valid, 1'b0);
         end
         step();
         ea   = lp ? s + 24'(k % len) : s + 24'(k);
         last = !lp && (k == len - 1);
         na   = lp ? s + 24'((k + 1) % len) : (last ? e : s + 24'(k + 1));
         chk("sample_valid", bus.sample_valid, 1'b1);
         chk("sample_data", bus.sample_out, rom_mem[ea[5:0]]);
         chk("sample_done", bus.done, last);
         chk("next_addr", bus.rom_addr, na);
         if (last) begin
            chk("done_state", bus.state, 2'b11);
            chk("done_busy", bus.busy, 1'b0);
         end
      end
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk_idle("stop");
   endtask

   initial begin
      logic [23:0] s;
      logic [23:0] e;
      logic        lp;
      int unsigned len;
      logic [7:0]  held;

      bus.play = 1'b0;
      bus.pause = 1'b0;
      bus.stop = 1'b0;
      bus.loop_en = 1'b0;
      bus.start_addr = '0;
      bus.end_addr = '0;
      for (int i = 0; i < 64; i++) rom_mem[i] = 8'($urandom);
      rom_mem[0] = 8'h55;
      rom_mem[1] = 8'h5C;
      rom_mem[5] = 8'h85;

      step();
      step();
      chk_idle("reset");
      chk("reset_bad", bus.bad_range, 1'b0);
      reset_n = 1'b1;
      step();
      chk_idle("post_reset");

      // Two-sample song, no loop.
      start_song(24'd0, 24'd1, 1'b0);
      run_song(24'd0, 24'd1, 1'b0, 0, 2);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("done_hold_valid", bus.sample_valid, 1'b0);
      end
      chk("done_hold_state", bus.state, 2'b11);
      chk("done_hold_sample", bus.sample_out, 8'h5C);

      // Same song looping, restarted from DONE.
      start_song(24'd0, 24'd1, 1'b1);
      run_song(24'd0, 24'd1, 1'b1, 0, 5);
      do_stop();

      // Single-sample song, then a rejected reversed range.
      start_song(24'd5, 24'd5, 1'b0);
      run_song(24'd5, 24'd5, 1'b0, 0, 1);
      bus.start_addr = 24'd6;
      bus.end_addr = 24'd5;
      bus.play = 1'b1;
      step();
      bus.play = 1'b0;
      chk("bad_range_pulse", bus.bad_range, 1'b1);
      chk("bad_range_state", bus.state, 2'b11);
      step();
      chk("bad_range_clear", bus.bad_range, 1'b0);
      chk("bad_range_state2", bus.state, 2'b11);

      // Pause exactly on a tick cycle, resume later.
      start_song(24'd10, 24'd13, 1'b0);
      run_song(24'd10, 24'd13, 1'b0, 0, 1);
      for (int unsigned j = 1; j < DIV; j++) begin
         step();
         chk("pre_pause_valid", bus.sample_valid, 1'b0);
      end
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b0;
      chk("pause_state", bus.state, 2'b10);
      chk("pause_valid", bus.sample_valid, 1'b0);
      chk("pause_busy", bus.busy, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("paused_valid", bus.sample_valid, 1'b0);
         chk("paused_addr", bus.rom_addr, 24'd11);
      end
      bus.play = 1'b1;
      step();
      bus.play = 1'b0;
      chk("resume_state", bus.state, 2'b01);
      chk("resume_valid", bus.sample_valid, 1'b0);
      step();
      chk("resume_sample_valid", bus.sample_valid, 1'b1);
      chk("resume_sample_data", bus.sample_out, rom_mem[11]);
      chk("resume_addr", bus.rom_addr, 24'd12);
      run_song(24'd10, 24'd13, 1'b0, 2, 4);

      // loop_en is live: requested at start, dropped before the end.
      start_song(24'd30, 24'd32, 1'b1);
      bus.loop_en = 1'b0;
      run_song(24'd30, 24'd32, 1'b0, 0, 3);

      // Top of the address space.
      start_song(24'hFFFFFD, 24'hFFFFFF, 1'b1);
      run_song(24'hFFFFFD, 24'hFFFFFF, 1'b1, 0, 7);
      do_stop();
      start_song(24'hFFFFFF, 24'hFFFFFF, 1'b0);
      run_song(24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 1);

      // Randomized songs.
      for (int r = 0; r < 6; r++) begin
         do_stop();
         s   = 24'($urandom_range(0, 40));
         len = $urandom_range(1, 5);
         e   = s + 24'(len - 1);
         lp  = 1'($urandom);
         start_song(s, e, lp);
         run_song(s, e, lp, 0, lp ? 2 * len + 1 : len);
      end

      // stop and play together mid-song.
      do_stop();
      start_song(24'd0, 24'd3, 1'b1);
      step();
      step();
      bus.stop = 1'b1;
      bus.play = 1'b1;
      step();
      bus.stop = 1'b0;
      bus.play = 1'b0;
      chk_idle("stop_play");
      for (int i = 0; i < 2 * DIV; i++) begin
         step();
         chk("stop_play_quiet", bus.sample_valid, 1'b0);
         chk("stop_play_state", bus.state, 2'b00);
      end

      // Asynchronous reset mid-play, just before a tick edge.
      start_song(24'd20, 24'd25, 1'b0);
      run_song(24'd20, 24'd25, 1'b0, 0, 1);
      held = rom_mem[20];
      chk("pre_reset_sample", bus.sample_out, held);
      for (int unsigned j = 1; j < DIV; j++) step();
      #2;
      reset_n = 1'b0;
      #1;
      chk_idle("async_reset");
      chk("async_reset_bad", bus.bad_range, 1'b0);
      step();
      chk_idle("reset_held");
      reset_n = 1'b1;
      step();
      chk_idle("reset_release");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
